// File: rtl/pool_nl_pkg.sv
// Shared types, widths and the output saturation helper for the
// pooling/non-linearity partial-sum accumulator.
// IN_W follows the codebase-wide `WID_PE_BITS (defaults to 16 if unset).
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

package pool_nl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ROW_MAX    = 64;
    localparam int MAX_PASSES = 16;
    localparam int IN_W       = `WID_PE_BITS;
    localparam int OUT_W      = 8;

    // Accumulator headroom covers MAX_PASSES full-scale partial sums.
    localparam int ACC_W   = IN_W + $clog2(MAX_PASSES);
    localparam int PIX_W   = $clog2(ROW_MAX + 1);
    localparam int PASS_W  = $clog2(MAX_PASSES + 1);
    localparam int IDX_W   = $clog2(ROW_MAX);
    localparam int SHIFT_W = 5;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

    // Clamp an accumulator-width value into the signed output range.
    function automatic logic signed [OUT_W-1:0] sat_to_out(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return SAT_HI[OUT_W-1:0];
        end else if (v < SAT_LO) begin
            return SAT_LO[OUT_W-1:0];
        end else begin
            return v[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pool_nl_requant.sv
// Combinational requantiser: optional ReLU, arithmetic right shift (floor),
// then saturation to the narrow output width.
// Optional feature macro: POOL_NL_RELU_EN (clamp negatives to zero first).
module pool_nl_requant
    import pool_nl_pkg::*;
(
    input  logic signed [ACC_W-1:0]   acc,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [OUT_W-1:0]   res
);

    logic signed [ACC_W-1:0] relu_v;
    logic signed [ACC_W-1:0] shifted_v;

    // ReLU, floor shift and saturate in that order.
    always_comb begin
`ifdef POOL_NL_RELU_EN
        relu_v = acc[ACC_W-1] ? '0 : acc;
`else
        relu_v = acc;
`endif
        shifted_v = relu_v >>> shift;
        res       = sat_to_out(shifted_v);
    end

endmodule

// File: rtl/pool_nl_psum_accum.sv
// Per-pixel channel partial-sum accumulator over a configurable number of
// passes, with a requantised valid/ready output stage.
// Optional feature macro: POOL_NL_RELU_EN (evaluated in pool_nl_requant).
module pool_nl_psum_accum
    import pool_nl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic        [PIX_W-1:0]   cfg_row_len,
    input  logic        [PASS_W-1:0]  cfg_num_passes,
    input  logic        [SHIFT_W-1:0] cfg_shift,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IN_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      busy,
    output logic                      done
);

    state_t state;
    state_t state_nxt;

    logic [PIX_W-1:0]   row_len;
    logic [PASS_W-1:0]  num_passes;
    logic [SHIFT_W-1:0] shift;
    logic [PIX_W-1:0]   pix_cnt;
    logic [PASS_W-1:0]  pass_cnt;
    // Set once the final beat of the row is taken; blocks further input.
    logic               all_in;

    logic signed [ACC_W-1:0] psum_buf [0:ROW_MAX-1];

    logic                    last_pass;
    logic                    last_pix;
    logic                    accept;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] prev_psum;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] requant_res;

    assign last_pass = (pass_cnt == num_passes - PASS_W'(1));
    assign last_pix  = (pix_cnt == row_len - PIX_W'(1));
    assign accept    = in_valid && in_ready;
    assign idx       = pix_cnt[IDX_W-1:0];
    assign in_ext    = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
    // First pass starts from zero, so the buffer is overwritten rather than added to.
    assign prev_psum = (pass_cnt == '0) ? '0 : psum_buf[idx];
    assign sum       = prev_psum + in_ext;

    pool_nl_requant u_requant (
        .acc   (sum),
        .shift (shift),
        .res   (requant_res)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs; the final pass stalls on a full output register.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !all_in && (!last_pass || !out_valid || out_ready);
                if (all_in && out_valid && out_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration latch and pixel/pass counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_len    <= '0;
            num_passes <= '0;
            shift      <= '0;
            pix_cnt    <= '0;
            pass_cnt   <= '0;
            all_in     <= 1'b0;
        end else if (state == IDLE && start) begin
            row_len    <= cfg_row_len;
            num_passes <= cfg_num_passes;
            shift      <= cfg_shift;
            pix_cnt    <= '0;
            pass_cnt   <= '0;
            all_in     <= 1'b0;
        end else if (accept) begin
            if (last_pix) begin
                pix_cnt <= '0;
                if (last_pass) begin
                    all_in <= 1'b1;
                end else begin
                    pass_cnt <= pass_cnt + PASS_W'(1);
                end
            end else begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

    // Row buffer holds running sums for every non-final pass.
    always_ff @(posedge clk) begin
        if (accept && !last_pass) begin
            psum_buf[idx] <= sum;
        end
    end

    // Output register; reloads on a same-cycle handshake and new final beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && last_pass) begin
            out_valid <= 1'b1;
            out_data  <= requant_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_nl_psum_accum.sv
// Randomised self-checking bench for pool_nl_psum_accum against a plain
// arithmetic model of per-pixel accumulation and requantisation.
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

module tb_pool_nl_psum_accum;
    import pool_nl_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic        [PIX_W-1:0]   cfg_row_len;
    logic        [PASS_W-1:0]  cfg_num_passes;
    logic        [SHIFT_W-1:0] cfg_shift;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [IN_W-1:0]    in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic                      busy;
    logic                      done;

    int total;
    int bad;
    int stim[$];

    pool_nl_psum_accum dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_row_len    (cfg_row_len),
        .cfg_num_passes (cfg_num_passes),
        .cfg_shift      (cfg_shift),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference requantiser: optional ReLU, floor division by 2^sh, clamp.
    function automatic longint model_q(input longint s_in, input int sh);
        longint s;
        longint d;
        longint q;
        s = s_in;
`ifdef POOL_NL_RELU_EN
        if (s < 0) s = 0;
`endif
        d = longint'(1) << sh;
        if (s >= 0) q = s / d;
        else q = -((-s + d - 1) / d);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Wrap a mathematical sum into the accumulator's two's-complement range.
    function automatic longint model_wrap(input longint s);
        longint m;
        longint r;
        m = longint'(1) << ACC_W;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    // mode: 0 = out_ready high, 1 = random out_ready, 2 = 5-cycle stall on first output
    task automatic run_row(input int rl, input int np, input int sh, input int mode, input bit start_mid);
        longint exp_q[$];
        int n;
        int idx;
        int got;
        int cyc;
        int budget;
        int done_cnt;
        int bp_left;
        int last_hs;
        bit held_valid;
        longint held;
        bit final_phase;
        longint s;

        n = rl * np;
        for (int pix = 0; pix < rl; pix++) begin
            s = 0;
            for (int p = 0; p < np; p++) s += stim[p * rl + pix];
            exp_q.push_back(model_q(model_wrap(s), sh));
        end

        @(negedge clk);
        cfg_row_len    = PIX_W'(rl);
        cfg_num_passes = PASS_W'(np);
        cfg_shift      = SHIFT_W'(sh);
        start          = 1'b1;
        in_valid       = 1'b0;
        out_ready      = 1'b1;

        idx = 0; got = 0; cyc = 0; done_cnt = 0; bp_left = -1; last_hs = -100;
        held_valid = 1'b0; held = 0;
        budget = n * 8 + 200;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge clk);
            if (start_mid && cyc == 2) begin
                start          = 1'b1;
                cfg_row_len    = PIX_W'(rl + 2);
                cfg_num_passes = PASS_W'(np + 1);
                cfg_shift      = SHIFT_W'(0);
            end else begin
                start          = 1'b0;
                cfg_row_len    = PIX_W'(rl);
                cfg_num_passes = PASS_W'(np);
                cfg_shift      = SHIFT_W'(sh);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bp_left < 0 && out_valid) bp_left = 5;
                    out_ready = !(bp_left > 0);
                    if (bp_left > 0) bp_left--;
                end
            endcase
            in_valid = (idx < n) && ($urandom_range(0, 3) != 0);
            in_data  = (idx < n) ? IN_W'(stim[idx]) : '0;
            #1;
            if (done) begin
                done_cnt++;
                check_val("done_lat", cyc - last_hs, 1);
            end
            final_phase = (idx >= (np - 1) * rl) && (idx < n);
            if (busy && idx < n && !final_phase) check_val("nf_rdy", in_ready, 1);
            if (held_valid && out_valid) check_val("hold", out_data, held);
            if (out_valid && !out_ready) begin
                if (final_phase) check_val("bp_rdy", in_ready, 0);
                held_valid = 1'b1;
                held = out_data;
            end else begin
                held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (got < exp_q.size()) check_val("out", out_data, exp_q[got]);
                else check_val("extra_out", 1, 0);
                got++;
                last_hs = cyc;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        if (done_cnt == 0) check_val("timeout", 0, 1);
        check_val("n_out", got, exp_q.size());
        check_val("n_in", idx, n);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check_val("done_once", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("idle_rdy", in_ready, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; cfg_row_len = '0; cfg_num_passes = '0; cfg_shift = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst = 1'b0;

        // Single pass, saturation both ways.
        stim = '{5, -3, 200, -200};
        run_row(4, 1, 0, 0, 1'b0);

        // Three passes, shift 2: pixel sums 60, -4, 3.
        stim = '{10, -8, 1, 20, 4, 1, 30, 0, 1};
        run_row(3, 3, 2, 0, 1'b0);

        // Output back-pressure on the final pass.
        stim = '{};
        for (int i = 0; i < 8; i++) stim.push_back($urandom_range(0, 600) - 300);
        run_row(4, 2, 1, 2, 1'b0);

        // Full depth, full-scale inputs.
        stim = '{};
        for (int i = 0; i < ROW_MAX * MAX_PASSES; i++) stim.push_back(32767);
        run_row(ROW_MAX, MAX_PASSES, 31, 0, 1'b0);

        // Start pulsed during RUN must be ignored.
        stim = '{};
        for (int i = 0; i < 6; i++) stim.push_back($urandom_range(0, 100) - 50);
        run_row(3, 2, 0, 0, 1'b1);

        // Random rows with random output stalls.
        for (int t = 0; t < 8; t++) begin
            int rl;
            int np;
            rl = $urandom_range(1, 12);
            np = $urandom_range(1, 5);
            stim = '{};
            for (int i = 0; i < rl * np; i++) stim.push_back(int'($urandom_range(0, 65535)) - 32768);
            run_row(rl, np, $urandom_range(0, 12), $urandom_range(0, 1), 1'b0);
        end

        // Reset in the middle of the first of two passes.
        @(negedge clk);
        cfg_row_len = PIX_W'(2); cfg_num_passes = PASS_W'(2); cfg_shift = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = IN_W'(99);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_rdy", in_ready, 0);
        check_val("mid_rst_ovld", out_valid, 0);
        check_val("mid_rst_odata", out_data, 0);
        check_val("mid_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        stim = '{7};
        run_row(1, 1, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool_nl_psum_accum.md
# pool_nl_psum_accum

Channel partial-sum accumulator and requantiser directly downstream of the pooling/non-linearity adder tree. Each tree result is one partial sum for one output pixel, covering one pass over a channel group. The block accumulates these partial sums per pixel across a configurable number of passes, using a row-wide buffer. On the final pass it applies ReLU, an arithmetic right shift and saturation, then emits the narrow result over a valid/ready stream to the output writer.

## Interface
- ROW_MAX, 64: max pixels per row; buffer depth.
- MAX_PASSES, 16: max channel-group passes per row.
- IN_W, `WID_PE_BITS: signed partial-sum width from the adder tree.
- OUT_W, 8: signed output width.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; latches cfg_*; ignored unless IDLE.
- cfg_row_len  in  $clog2(ROW_MAX+1)  pixels per row, 1..ROW_MAX.
- cfg_num_passes  in  $clog2(MAX_PASSES+1)  passes, 1..MAX_PASSES.
- cfg_shift  in  5  arithmetic right-shift amount, 0..31.
- in_valid  in  1  partial sum present.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  IN_W  signed partial sum (adder_tree_out).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  signed requantised result.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the row completes.

## Operation
- Accumulator width: ACC_W = IN_W + $clog2(MAX_PASSES). in_data is sign-extended to ACC_W. Accumulator adds wrap; no saturation inside the accumulator.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN on start. On that transition: pix_cnt = 0, pass_cnt = 0, and cfg values are latched.
  - RUN → DONE when the last pixel of the last pass completes its output handshake.
  - DONE → IDLE after exactly one cycle. done = 1 only in DONE.
- An input beat is accepted when in_valid && in_ready.
  - pass_cnt == 0: buf[pix_cnt] = in_data (overwrite).
  - 0 < pass_cnt < num_passes-1: buf[pix_cnt] += in_data.
  - pass_cnt == num_passes-1: sum = buf[pix_cnt] + in_data, which is sent to the requantiser. buf is not written.
  - num_passes == 1: the first pass is also the last, so sum = in_data.
- Counters advance only on an accepted beat.
  - pix_cnt wraps from row_len-1 to 0.
  - pass_cnt increments on that wrap.
- Requantise, in order:
  - ReLU (see Configuration).
  - Arithmetic shift right by cfg_shift; floor, no rounding.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output is a single register stage.
  - in_ready = (state == RUN) && (pass_cnt != last || !out_valid || out_ready).
  - Non-final passes are never back-pressured.
  - in_ready = 0 in IDLE and DONE.
- start while in RUN or DONE is ignored. Input beats in IDLE are not accepted.

## Timing
- Reset values: in_ready = 0, out_valid = 0, out_data = 0, busy = 0, done = 0; state IDLE; counters 0. Buffer contents are don't-care.
- Latency: out_valid rises on the clock edge after a final-pass beat is accepted (1 cycle).
- out_data is held stable while out_valid && !out_ready.
- Throughput: 1 beat/cycle when out_ready is held high.
- Simultaneous output handshake and new final-pass acceptance in the same cycle: the register reloads and out_valid stays 1.
- done fires the cycle after the last output handshake.
- rst asserted mid-row: everything returns to reset values immediately and any pending output is dropped. A fresh start is required.

## Configuration
- POOL_NL_RELU_EN defined: values < 0 are clamped to 0 before the shift, so out_data ≥ 0.
- POOL_NL_RELU_EN undefined: signed pass-through; negative values are shifted and saturated normally.

## Structure
- pool_nl_pkg contains:
  - the state enum (IDLE, RUN, DONE);
  - ACC_W and the counter width localparams;
  - a sat_to_out function.
- One sub-module, pool_nl_requant: combinational ReLU/shift/saturate, ACC_W in, OUT_W out, with POOL_NL_RELU_EN evaluated inside it.
- The top contains the FSM, counters, buffer and output register.

## Test plan
- row_len=4, passes=1, shift=0, in 5,-3,200,-200.
  - RELU_EN: out 5, 0, 127, 0.
  - Without RELU_EN: out 5, -3, 127, -128.
- row_len=3, passes=3, shift=2, pixel 0 gets 10,20,30 (sum 60) → 15. Pixel 1 gets -8,4,0 → 0 with RELU_EN, -1 without.
- Back-pressure: out_ready=0 for 5 cycles on the final pass.
  - in_ready is low while out_valid=1.
  - out_data is held.
  - No beat is lost or duplicated; 4 outputs appear in order.
- Full depth: row_len=ROW_MAX, passes=MAX_PASSES, every in_data = 32767, shift 31.
  - No accumulator overflow; sum = 32767·16.
  - Each output = 0 (shift 31 floors this positive sum to 0).
  - done pulses once.
- rst asserted mid pass 1 of 2.
  - Outputs return to reset values.
  - A following start with passes=1, in 7 → out 7 (no stale sum).
- start pulsed while in RUN: config unchanged; done still occurs after the originally latched row_len × num_passes beats.
